// File: rtl/pixl_feeder.sv
// Pixel-window feeder: collects N_PIX pixel bytes, streams them to a UART TX FIFO,
// then waits (bounded by TIMEOUT) for a single response byte from the UART RX FIFO.
module pixl_feeder #(
    parameter int unsigned N_PIX   = 9,
    parameter int unsigned TIMEOUT = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    output logic       wr_uart,
    output logic [7:0] w_data,
    input  logic       tx_full,
    output logic       rd_uart,
    input  logic [7:0] r_data,
    input  logic       rx_empty,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       timeout,
    output logic       busy
);

    localparam int unsigned IW = $clog2(N_PIX + 1);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_PIX - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        LOAD,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    pix_buf [N_PIX];
    logic [IW-1:0] idx;
    logic [IW-1:0] sidx;
    logic [CW-1:0] cnt;
    logic          got_byte;

    // Every strobe is gated by reset so nothing fires in the cycle reset is sampled.
    always_comb begin
        state_next   = state;
        pix_ready    = 1'b0;
        wr_uart      = 1'b0;
        w_data       = '0;
        rd_uart      = 1'b0;
        result_valid = 1'b0;
        timeout      = 1'b0;
        busy         = reset && (state != LOAD);
        case (state)
            LOAD: begin
                pix_ready = reset;
                if (pix_valid && idx == LAST_IDX) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                wr_uart = reset && !tx_full;
                w_data  = reset ? pix_buf[sidx] : '0;
                if (!tx_full && sidx == LAST_IDX) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!rx_empty) begin
                    rd_uart    = reset;
                    state_next = DONE;
                end else if (cnt == LAST_CNT) begin
                    timeout    = reset;
                    state_next = DONE;
                end
            end
            DONE: begin
                result_valid = reset && got_byte;
                state_next   = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= LOAD;
            idx      <= '0;
            sidx     <= '0;
            cnt      <= '0;
            result   <= '0;
            got_byte <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                LOAD: begin
                    if (pix_valid) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            sidx <= '0;
                        end
                    end
                end
                SEND: begin
                    if (!tx_full) begin
                        sidx <= sidx + 1'b1;
                        if (sidx == LAST_IDX) begin
                            cnt <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (!rx_empty) begin
                        result   <= r_data;
                        got_byte <= 1'b1;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        got_byte <= 1'b0;
                    end
                end
                DONE: idx <= '0;
                default: ;
            endcase
        end
    end

    // Window storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (pix_ready && pix_valid) begin
            pix_buf[idx] <= pix_data;
        end
    end

endmodule

// File: tb/tb_pixl_feeder.sv
// Scoreboard bench for pixl_feeder: windows and responses are queued as expectations,
// a negedge monitor compares every DUT strobe against them.
module tb_pixl_feeder;

    localparam int unsigned N  = 9;
    localparam int unsigned TO = 16;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data  = 8'h00;
    logic       tx_full   = 1'b0;
    logic [7:0] r_data    = 8'h00;
    logic       rx_empty  = 1'b1;
    logic       pix_ready;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       rd_uart;
    logic [7:0] result;
    logic       result_valid;
    logic       timeout;
    logic       busy;

    pixl_feeder #(.N_PIX(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full),
        .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty), .result(result),
        .result_valid(result_valid), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_wr[$];
    logic [8:0] exp_evt[$];   // {is_timeout, response byte}
    logic [7:0] model_result = 8'h00;
    int  mon_txn_wr   = 0;
    int  mon_acc      = 0;
    int  last_acc_cyc = 0;
    int  last_wr_cyc  = 0;
    bit  rd_seen      = 1'b0;
    int  tx_mode      = 0;
    bit  strict       = 1'b0;
    int  stall_cnt    = 0;
    bit  stalled      = 1'b0;
    logic [7:0] rxq[$];
    int  resp_mode    = 0;
    logic [7:0] resp_byte = 8'h00;
    int  resp_dly     = 0;
    bit  resp_armed   = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [7:0] e;
        logic [8:0] ev;
        if (!reset) begin
            chk("reset_strobes", int'({wr_uart, rd_uart, result_valid, timeout, pix_ready}), 0);
        end else begin
            if (wr_uart || rd_uart) chk("rd_wr_overlap", int'(wr_uart & rd_uart), 0);
            if (pix_valid && pix_ready) begin
                mon_acc++;
                if (mon_acc == N) begin
                    mon_acc      = 0;
                    last_acc_cyc = cyc;
                end
            end
            if (wr_uart) begin
                chk("wr_expected", int'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    chk("w_data", int'(w_data), int'(e));
                    if (strict) begin
                        chk("wr_latency", cyc, last_acc_cyc + 1 + mon_txn_wr);
                        chk("busy_send", int'(busy), 1);
                    end
                    if (tx_mode == 2 && mon_txn_wr == 3) chk("stall_gap", cyc - last_wr_cyc, 6);
                    last_wr_cyc = cyc;
                    mon_txn_wr++;
                end
            end
            if (rd_uart) begin
                chk("rd_after_send", mon_txn_wr, N);
                rd_seen = 1'b1;
            end
            if (timeout) begin
                chk("evt_expected", int'(exp_evt.size() > 0), 1);
                if (exp_evt.size() > 0) begin
                    ev = exp_evt.pop_front();
                    chk("timeout_expected", int'(ev[8]), 1);
                    chk("timeout_cycle", cyc, last_wr_cyc + TO);
                    chk("result_hold", int'(result), int'(model_result));
                end
                mon_txn_wr = 0;
            end
            if (result_valid) begin
                chk("evt_expected", int'(exp_evt.size() > 0), 1);
                if (exp_evt.size() > 0) begin
                    ev = exp_evt.pop_front();
                    chk("byte_expected", int'(ev[8]), 0);
                    chk("result", int'(result), int'(ev[7:0]));
                    model_result = ev[7:0];
                end
                mon_txn_wr = 0;
            end
        end
    end

    // UART FIFO models: RX queue with scheduled responses, TX back-pressure
    always @(posedge clk) begin
        #1;
        if (rd_seen) begin
            if (rxq.size() > 0) rxq.delete(0);
            rd_seen = 1'b0;
        end
        if (resp_armed) begin
            if (resp_mode == 1) begin
                rxq.push_back(resp_byte);
                resp_armed = 1'b0;
            end else if (resp_mode == 2 && mon_txn_wr == N) begin
                if (resp_dly == 0) begin
                    rxq.push_back(resp_byte);
                    resp_armed = 1'b0;
                end else begin
                    resp_dly--;
                end
            end
        end
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
        case (tx_mode)
            1: tx_full = ($urandom_range(0, 3) == 0);
            2: begin
                if (stall_cnt > 0) begin
                    tx_full = 1'b1;
                    stall_cnt--;
                end else if (!stalled && mon_txn_wr == 3) begin
                    stalled   = 1'b1;
                    tx_full   = 1'b1;
                    stall_cnt = 4;
                end else begin
                    tx_full = 1'b0;
                end
            end
            default: tx_full = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_window(input logic [7:0] px [N], input bit gaps);
        bit accepted;
        for (int i = 0; i < N; i++) exp_wr.push_back(px[i]);
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                pix_valid = 1'b0;
                tick();
            end
            pix_valid = 1'b1;
            pix_data  = px[i];
            accepted  = 1'b0;
            for (int t = 0; t < 200 && !accepted; t++) begin
                @(negedge clk);
                accepted = pix_ready;
                tick();
            end
            chk("pix_accept", int'(accepted), 1);
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300 && exp_evt.size() != 0; t++) tick();
        chk("txn_complete", exp_evt.size(), 0);
        if (exp_evt.size() != 0) begin
            exp_evt.delete();
            exp_wr.delete();
            mon_txn_wr = 0;
        end
        tick();
    endtask

    task automatic run_txn(input logic [7:0] px [N], input int tm, input int rm,
                           input logic [7:0] rb, input int rd, input bit st, input bit gaps);
        tx_mode    = tm;
        stalled    = 1'b0;
        stall_cnt  = 0;
        strict     = st;
        resp_mode  = rm;
        resp_byte  = rb;
        resp_dly   = rd;
        resp_armed = (rm != 0);
        exp_evt.push_back(rm == 0 ? {1'b1, 8'h00} : {1'b0, rb});
        load_window(px, gaps);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input logic exp_ready);
        chk("rst_pix_ready", int'(pix_ready), int'(exp_ready));
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_w_data", int'(w_data), 0);
        chk("rst_wr_rd", int'({wr_uart, rd_uart}), 0);
        chk("rst_valid_to", int'({result_valid, timeout}), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] px [N];
        reset = 1'b0;
        repeat (3) tick();
        check_reset_outputs(1'b0);
        reset = 1'b1;
        #1;
        check_reset_outputs(1'b1);

        // Pixels 0..8, free TX, no response -> timeout, result stays 0
        for (int i = 0; i < N; i++) px[i] = 8'(i);
        run_txn(px, 0, 0, 8'h00, 0, 1'b1, 1'b0);
        // Pixels 1..9 with a 5-cycle TX stall after the 3rd write, response 2D
        for (int i = 0; i < N; i++) px[i] = 8'(i + 1);
        run_txn(px, 2, 2, 8'h2D, 0, 1'b0, 1'b0);
        // Response sitting in RX FIFO throughout LOAD/SEND
        for (int i = 0; i < N; i++) px[i] = 8'($urandom);
        run_txn(px, 0, 1, 8'h5A, 0, 1'b1, 1'b1);
        // Timeout must keep the previous nonzero result
        for (int i = 0; i < N; i++) px[i] = 8'($urandom);
        run_txn(px, 1, 0, 8'h00, 0, 1'b0, 1'b1);
        // Byte arrives on the very cycle the counter reaches TIMEOUT-1
        for (int i = 0; i < N; i++) px[i] = 8'($urandom);
        run_txn(px, 0, 2, 8'hC3, TO - 1, 1'b1, 1'b0);

        // Reset pulse after the 4th write aborts the transaction
        tx_mode    = 0;
        strict     = 1'b0;
        resp_armed = 1'b0;
        for (int i = 0; i < N; i++) px[i] = 8'(8'hA0 + i);
        load_window(px, 1'b0);
        for (int t = 0; t < 50 && mon_txn_wr < 4; t++) tick();
        chk("reached_4_writes", mon_txn_wr, 4);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_wr.delete();
        exp_evt.delete();
        rxq.delete();
        mon_txn_wr   = 0;
        mon_acc      = 0;
        model_result = 8'h00;
        #1;
        check_reset_outputs(1'b1);
        repeat (6) tick();
        for (int i = 0; i < N; i++) px[i] = 8'(8'h40 + i);
        run_txn(px, 0, 2, 8'h77, 3, 1'b1, 1'b0);

        // Randomized transactions
        for (int n = 0; n < 20; n++) begin
            int tm;
            int rm;
            tm = int'($urandom_range(0, 1));
            rm = int'($urandom_range(0, 2));
            for (int i = 0; i < N; i++) px[i] = 8'($urandom);
            run_txn(px, tm, rm, 8'($urandom), int'($urandom_range(0, TO - 1)),
                    (tm == 0), bit'($urandom_range(0, 1)));
        end

        repeat (5) tick();
        chk("exp_wr_drained", exp_wr.size(), 0);
        chk("exp_evt_drained", exp_evt.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
